if_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined CPU.
- Drives the instruction-memory address (i_addr) into the memory block and samples the combinational instruction word (ir) the same cycle.
- Buffers fetched words in a 2-entry prefetch queue and hands them to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects from execute, and stops fetching on HALT.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if.sv | 13 +
 rtl/if_prefetch_q.sv | 68 ++++++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: default widths and opcode encodings.
package if_stage_pkg;

    localparam int PKG_ADDR_W = 8;
    localparam int PKG_INST_W = 16;
    localparam int OPC_W      = 5;

    // Opcode field lives in the top OPC_W bits of the instruction word.
    localparam logic [OPC_W-1:0] OP_HALT = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00100;
    localparam logic [OPC_W-1:0] OP_JZ   = 5'b01000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-to-decode valid/ready handshake.
interface if_stage_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
);
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;

    modport master (output id_valid, output id_inst, output id_pc, input id_ready);
    modport slave  (input id_valid, input id_inst, input id_pc, output id_ready);
endinterface

// File: rtl/if_prefetch_q.sv
// Two-entry prefetch FIFO holding {instruction, pc}. Head entry drives the
// outputs directly, so a word is visible the cycle after it is pushed.
module if_prefetch_q
    import if_stage_pkg::*;
#(
    parameter int DW     = PKG_INST_W,
    parameter int AW     = PKG_ADDR_W,
    parameter int QDEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    input  logic [AW-1:0] i_pc,
    output logic          o_valid,
    output logic          o_full,
    output logic [DW-1:0] o_data,
    output logic [AW-1:0] o_pc
);
    logic [1:0][DW-1:0] r_data;
    logic [1:0][AW-1:0] r_pc;
    logic               r_wr;
    logic               r_rd;
    logic [1:0]         r_count;

    logic w_pop;
    logic w_push;

    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'(QDEPTH));
    assign o_data  = r_data[r_rd];
    assign o_pc    = r_pc[r_rd];

    // Guard against popping empty or pushing into a full queue without a pop.
    assign w_pop  = i_pop && o_valid;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage, pointers and occupancy; flush resets pointers but keeps data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_pc    <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= i_data;
                r_pc[r_wr]   <= i_pc;
                r_wr         <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, halt and redirect control around a 2-entry
// prefetch queue feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = PKG_ADDR_W,
    parameter int                INST_W   = PKG_INST_W,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    output logic [ADDR_W-1:0] i_addr,
    input  logic [INST_W-1:0] ir,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    if_stage_if.master        dec
);
    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_q_valid;
    logic              w_q_full;
    logic [OPC_W-1:0]  w_opcode;

    assign w_opcode     = ir[INST_W-1 -: OPC_W];
    assign i_addr       = r_pc;
    assign halted       = (r_state == ST_HALT);
    assign dec.id_valid = w_q_valid;

    // Next PC / halt state and queue controls; start beats redirect beats fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush     = 1'b0;
        w_push      = 1'b0;
        w_pop       = enable && w_q_valid && dec.id_ready;
        if (enable) begin
            if (start) begin
                w_flush     = 1'b1;
                w_pc_nxt    = RESET_PC;
                w_state_nxt = ST_RUN;
            end else if (redirect_valid) begin
                w_flush     = 1'b1;
                w_pc_nxt    = redirect_addr;
                w_state_nxt = ST_RUN;
            end else if (r_state == ST_RUN && (!w_q_full || w_pop)) begin
                w_push   = 1'b1;
                w_pc_nxt = r_pc + ADDR_W'(1);
                if (w_opcode == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end
            end
        end
    end

    // PC and run/halt state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    if_prefetch_q #(
        .DW     (INST_W),
        .AW     (ADDR_W),
        .QDEPTH (QDEPTH)
    ) u_q (
        .clock   (clock),
        .reset   (reset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (ir),
        .i_pc    (r_pc),
        .o_valid (w_q_valid),
        .o_full  (w_q_full),
        .o_data  (dec.id_inst),
        .o_pc    (dec.id_pc)
    );
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage: reset, stall, redirect, halt/start,
// PC wrap, enable freeze and asynchronous reset.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        start;
    logic [7:0]  i_addr;
    logic [15:0] ir;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        halted;

    logic [15:0] mem [256];
    int total = 0;
    int bad   = 0;

    if_stage_if #(.ADDR_W(8), .INST_W(16)) dec ();

    if_stage dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .i_addr         (i_addr),
        .ir             (ir),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halted         (halted),
        .dec            (dec)
    );

    assign ir = mem[i_addr];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0; enable = 1'b1; start = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 8'h00; dec.id_ready = 1'b0;
        step;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1; start = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 8'h00; dec.id_ready = 1'b1;
        step;
        total++; if (i_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h want=00", i_addr); end
        total++; if (dec.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", dec.id_valid); end
        total++; if (dec.id_inst !== 16'h0) begin bad++; $display("FAIL rst_inst got=%h want=0000", dec.id_inst); end
        total++; if (dec.id_pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h want=00", dec.id_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            total++;
            if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'(k) || dec.id_inst !== mem[k] || i_addr !== 8'(k + 1)) begin
                bad++;
                $display("FAIL stream%0d got v=%b pc=%h inst=%h addr=%h want v=1 pc=%h inst=%h addr=%h",
                         k, dec.id_valid, dec.id_pc, dec.id_inst, i_addr, 8'(k), mem[k], 8'(k + 1));
            end
        end
    endtask

    task automatic test_stall;
        do_reset;
        for (int k = 0; k < 4; k++) step;
        total++; if (i_addr !== 8'h02) begin bad++; $display("FAIL stall_addr got=%h want=02", i_addr); end
        total++; if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'h00) begin
            bad++; $display("FAIL stall_head got v=%b pc=%h want v=1 pc=00", dec.id_valid, dec.id_pc); end
        dec.id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'(k) || dec.id_inst !== mem[k]) begin
                bad++;
                $display("FAIL drain%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         k, dec.id_valid, dec.id_pc, dec.id_inst, 8'(k), mem[k]);
            end
            step;
        end
    endtask

    task automatic test_redirect;
        do_reset;
        redirect_valid = 1'b1; redirect_addr = 8'h07;
        step;
        redirect_valid = 1'b0;
        step;
        step;
        total++; if (dec.id_pc !== 8'h07 || i_addr !== 8'h09) begin
            bad++; $display("FAIL redir_fill got pc=%h addr=%h want pc=07 addr=09", dec.id_pc, i_addr); end
        redirect_valid = 1'b1; redirect_addr = 8'h00; dec.id_ready = 1'b1;
        step;
        redirect_valid = 1'b0;
        total++; if (dec.id_valid !== 1'b0 || i_addr !== 8'h00) begin
            bad++; $display("FAIL redir_flush got v=%b addr=%h want v=0 addr=00", dec.id_valid, i_addr); end
        step;
        total++; if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'h00) begin
            bad++; $display("FAIL redir_first got v=%b pc=%h want v=1 pc=00", dec.id_valid, dec.id_pc); end
        step;
        total++; if (dec.id_pc !== 8'h01) begin bad++; $display("FAIL redir_second got pc=%h want=01", dec.id_pc); end
    endtask

    task automatic test_halt;
        mem[5] = {OP_HALT, 11'h000};
        start = 1'b1;
        step;
        start = 1'b0;
        total++; if (dec.id_valid !== 1'b0 || i_addr !== 8'h00) begin
            bad++; $display("FAIL start_flush got v=%b addr=%h want v=0 addr=00", dec.id_valid, i_addr); end
        for (int k = 0; k < 6; k++) begin
            step;
            total++;
            if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'(k) || dec.id_inst !== mem[k]) begin
                bad++;
                $display("FAIL halt_word%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         k, dec.id_valid, dec.id_pc, dec.id_inst, 8'(k), mem[k]);
            end
        end
        total++; if (halted !== 1'b1 || i_addr !== 8'h06) begin
            bad++; $display("FAIL halt_set got h=%b addr=%h want h=1 addr=06", halted, i_addr); end
        step;
        step;
        total++; if (dec.id_valid !== 1'b0 || halted !== 1'b1 || i_addr !== 8'h06) begin
            bad++; $display("FAIL halt_hold got v=%b h=%b addr=%h want v=0 h=1 addr=06", dec.id_valid, halted, i_addr); end
        start = 1'b1;
        step;
        start = 1'b0;
        mem[5] = {OP_ADDI, 3'b000, 8'h05};
        total++; if (halted !== 1'b0 || i_addr !== 8'h00) begin
            bad++; $display("FAIL halt_restart got h=%b addr=%h want h=0 addr=00", halted, i_addr); end
        step;
        total++; if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'h00) begin
            bad++; $display("FAIL restart_first got v=%b pc=%h want v=1 pc=00", dec.id_valid, dec.id_pc); end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1; redirect_addr = 8'hFE;
        step;
        redirect_valid = 1'b0;
        step;
        total++; if (dec.id_pc !== 8'hFE || dec.id_inst !== mem[254]) begin
            bad++; $display("FAIL wrap_fe got pc=%h inst=%h want pc=fe inst=%h", dec.id_pc, dec.id_inst, mem[254]); end
        step;
        total++; if (dec.id_pc !== 8'hFF) begin bad++; $display("FAIL wrap_ff got pc=%h want=ff", dec.id_pc); end
        step;
        total++; if (dec.id_pc !== 8'h00 || i_addr !== 8'h01) begin
            bad++; $display("FAIL wrap_00 got pc=%h addr=%h want pc=00 addr=01", dec.id_pc, i_addr); end
    endtask

    task automatic test_enable;
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            total++;
            if (dec.id_valid !== 1'b1 || dec.id_pc !== 8'h00 || i_addr !== 8'h01) begin
                bad++;
                $display("FAIL freeze%0d got v=%b pc=%h addr=%h want v=1 pc=00 addr=01", k, dec.id_valid, dec.id_pc, i_addr);
            end
        end
        enable = 1'b1;
        step;
        total++; if (dec.id_pc !== 8'h01 || i_addr !== 8'h02) begin
            bad++; $display("FAIL unfreeze got pc=%h addr=%h want pc=01 addr=02", dec.id_pc, i_addr); end
        #3;
        reset = 1'b0;
        #1;
        total++; if (dec.id_valid !== 1'b0 || i_addr !== 8'h00 || halted !== 1'b0) begin
            bad++; $display("FAIL async_rst got v=%b addr=%h h=%b want v=0 addr=00 h=0", dec.id_valid, i_addr, halted); end
        step;
        reset = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < 256; n++) mem[n] = {OP_ADDI, 3'b000, 8'(n)};
        test_reset;
        test_stall;
        test_redirect;
        test_halt;
        test_wrap;
        test_enable;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
